// File: rtl/fpga_rst_pkg.sv
// Shared types and constants for the PLL-downstream reset sequencer.
//   rst_seq_state_t : sequencer FSM states
//   DEF_*           : default parameter values for fpga_rst_seq
//   LOSS_CNT_W      : width of the saturating lock-loss counter
//   cnt_w()         : counter width for a modulus, never below 1 bit
package fpga_rst_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } rst_seq_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_LOCK_STABLE_CYC = 256;
    localparam int DEF_NUM_STAGES      = 3;
    localparam int DEF_STAGE_GAP_CYC   = 16;
    localparam int DEF_LOSS_FILTER_CYC = 4;

    localparam int LOSS_CNT_W = 8;

    // $clog2(1) is 0; a counter that only ever holds 0 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpga_sync_bit.sv
// Single-bit flop-chain synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into every flop
//   d     : input, may be asynchronous to clk
//   q     : synchronized output, STAGES edges behind d
// Tied to d=1 it doubles as a reset bridge: async assert, sync release.
module fpga_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= {STAGES{RST_VAL}};
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer downstream of the system PLL.
// Waits for a stable PLL lock, then releases NUM_STAGES consumer resets in
// order, STAGE_GAP_CYC apart. A filtered lock loss while running drops all
// stage resets at once, sets a sticky flag and bumps a saturating counter.
//   clk              : system clock
//   rst_n            : asynchronous active-low reset
//   pll_locked       : PLL lock flag, asynchronous to clk
//   clr_sticky       : 1-cycle pulse, clears lock_lost_sticky
//   rst_stage_n      : per-stage active-low resets, registered
//   sys_ready        : high only while all stages are released (S_RUN)
//   lock_lost_sticky : set on each filtered loss, cleared by clr_sticky
//   lock_loss_cnt    : saturating count of filtered losses
module fpga_rst_seq
    import fpga_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int STAGE_GAP_CYC   = DEF_STAGE_GAP_CYC,
    parameter int LOSS_FILTER_CYC = DEF_LOSS_FILTER_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  clr_sticky,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  sys_ready,
    output logic                  lock_lost_sticky,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int STAB_W = cnt_w(LOCK_STABLE_CYC);
    localparam int GAP_W  = cnt_w(STAGE_GAP_CYC);
    localparam int LOSS_W = cnt_w(LOSS_FILTER_CYC);
    localparam int IDX_W  = $clog2(NUM_STAGES) + 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYC - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic rst_int_n;
    logic lock_s;

    // Reset bridge: every internal flop, including the lock synchronizer,
    // leaves reset SYNC_STAGES edges after rst_n rises.
    fpga_sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_rst_bridge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_int_n)
    );

    fpga_sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_int_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    rst_seq_state_t    state;
    logic [STAB_W-1:0] stab_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state            <= S_WAIT_LOCK;
            stab_cnt         <= '0;
            gap_cnt          <= '0;
            loss_cnt         <= '0;
            idx              <= '0;
            rst_stage_n      <= '0;
            sys_ready        <= 1'b0;
            lock_lost_sticky <= 1'b0;
            lock_loss_cnt    <= '0;
        end else begin
            // A loss later in this block overrides the clear: set wins.
            if (clr_sticky) lock_lost_sticky <= 1'b0;

            case (state)
                S_WAIT_LOCK: begin
                    rst_stage_n <= '0;
                    sys_ready   <= 1'b0;
                    if (lock_s) begin
                        state    <= S_STABLE;
                        stab_cnt <= '0;
                    end
                end

                S_STABLE: begin
                    if (!lock_s) begin
                        state    <= S_WAIT_LOCK;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        stab_cnt       <= '0;
                        rst_stage_n[0] <= 1'b1;
                        idx            <= '0;
                        gap_cnt        <= '0;
                        if (NUM_STAGES == 1) begin
                            state     <= S_RUN;
                            sys_ready <= 1'b1;
                            loss_cnt  <= '0;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (!lock_s) begin
                        // Lock dropped before the system came up: restart
                        // quietly, this is not a counted loss.
                        state       <= S_WAIT_LOCK;
                        rst_stage_n <= '0;
                        gap_cnt     <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        idx     <= idx_nxt;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (IDX_W'(k) == idx_nxt) rst_stage_n[k] <= 1'b1;
                        end
                        if (idx_nxt == IDX_LAST) begin
                            state     <= S_RUN;
                            sys_ready <= 1'b1;
                            loss_cnt  <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (lock_s) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        // LOSS_FILTER_CYC consecutive unlocked cycles.
                        state            <= S_WAIT_LOCK;
                        loss_cnt         <= '0;
                        rst_stage_n      <= '0;
                        sys_ready        <= 1'b0;
                        lock_lost_sticky <= 1'b1;
                        if (lock_loss_cnt != '1)
                            lock_loss_cnt <= lock_loss_cnt + 1'b1;
                    end else begin
                        loss_cnt <= loss_cnt + 1'b1;
                    end
                end

                default: state <= S_WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Scoreboard bench for fpga_rst_seq (SYNC=2, STABLE=8, STAGES=3, GAP=4,
// FILTER=4). Stimulus tasks push the expected output word and the clock
// edge it must appear on; the monitor pops an entry whenever the sampled
// outputs change and compares both.
module tb_fpga_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       clr_sticky = 1'b0;
    logic [2:0] rst_stage_n;
    logic       sys_ready;
    logic       lock_lost_sticky;
    logic [7:0] lock_loss_cnt;

    fpga_rst_seq #(
        .SYNC_STAGES     (2),
        .LOCK_STABLE_CYC (8),
        .NUM_STAGES      (3),
        .STAGE_GAP_CYC   (4),
        .LOSS_FILTER_CYC (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_locked       (pll_locked),
        .clr_sticky       (clr_sticky),
        .rst_stage_n      (rst_stage_n),
        .sys_ready        (sys_ready),
        .lock_lost_sticky (lock_lost_sticky),
        .lock_loss_cnt    (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [12:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_loss = 0;
    bit   mon_en = 1'b0;

    // Expected-output model: {stages, ready, sticky, count}
    logic [2:0] m_stg    = '0;
    logic       m_rdy    = 1'b0;
    logic       m_sticky = 1'b0;
    logic [7:0] m_cnt    = '0;

    function automatic logic [12:0] outs();
        return {rst_stage_n, sys_ready, lock_lost_sticky, lock_loss_cnt};
    endfunction

    function automatic void push(input int c);
        exp_t e;
        e.cyc = c;
        e.val = {m_stg, m_rdy, m_sticky, m_cnt};
        q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every change of the output word must match the queue head.
    logic [12:0] prev = '0;
    always @(negedge clk) begin
        logic [12:0] cur;
        exp_t        e;
        cur = outs();
        if (mon_en && cur !== prev) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: cyc %0d got %h", cyc, cur);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    n_fail++;
                    $display("FAIL out_change: cyc %0d got %h, expected cyc %0d val %h",
                             cyc, cur, e.cyc, e.val);
                end
            end
            prev = cur;
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Lock rises from a settled-low state with the FSM in S_WAIT_LOCK.
    task automatic lock_up();
        int c0;
        @(negedge clk);
        pll_locked = 1'b1;
        c0 = cyc;
        m_stg = 3'b001; push(c0 + 11);
        m_stg = 3'b011; push(c0 + 15);
        m_stg = 3'b111; m_rdy = 1'b1; push(c0 + 19);
        wait_to(c0 + 19);
    endtask

    // Filtered loss from S_RUN; optionally pulse clr_sticky on the loss edge.
    task automatic loss(input bit clr_same);
        int c0;
        @(negedge clk);
        pll_locked = 1'b0;
        c0 = cyc;
        m_stg = '0; m_rdy = 1'b0; m_sticky = 1'b1;
        if (m_cnt != 8'hff) m_cnt = m_cnt + 1'b1;
        push(c0 + 6);
        n_loss++;
        if (clr_same) begin
            wait_to(c0 + 5);
            clr_sticky = 1'b1;
            wait_to(c0 + 6);
            clr_sticky = 1'b0;
        end else begin
            wait_to(c0 + 6);
        end
    endtask

    task automatic clr_alone();
        int c0;
        @(negedge clk);
        clr_sticky = 1'b1;
        c0 = cyc;
        m_sticky = 1'b0;
        push(c0 + 1);
        @(negedge clk);
        clr_sticky = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;

        // Reset state, async assertion
        #2 rst_n = 1'b0;
        #1;
        check("reset_stage", 32'(rst_stage_n), 32'h0);
        check("reset_ready", 32'(sys_ready), 32'h0);
        check("reset_sticky", 32'(lock_lost_sticky), 32'h0);
        check("reset_cnt", 32'(lock_loss_cnt), 32'h0);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 1-cycle lock drop at stab_cnt=5 restarts the stability count
        @(negedge clk);
        pll_locked = 1'b1;
        c0 = cyc;
        m_stg = 3'b001; push(c0 + 18);
        m_stg = 3'b011; push(c0 + 22);
        m_stg = 3'b111; m_rdy = 1'b1; push(c0 + 26);
        wait_to(c0 + 6);
        pll_locked = 1'b0;
        wait_to(c0 + 7);
        pll_locked = 1'b1;
        wait_to(c0 + 17);
        check("glitch_no_early_release", 32'(rst_stage_n), 32'h0);
        wait_to(c0 + 26);
        check("glitch_cnt_zero", 32'(lock_loss_cnt), 32'h0);

        // 3-cycle drop in S_RUN is filtered, 4-cycle drop is a loss
        @(negedge clk);
        pll_locked = 1'b0;
        c0 = cyc;
        wait_to(c0 + 3);
        pll_locked = 1'b1;
        wait_to(c0 + 10);
        check("filtered_ready", 32'(sys_ready), 32'h1);
        loss(1'b0);
        check("loss_sticky", 32'(lock_lost_sticky), 32'h1);
        check("loss_cnt1", 32'(lock_loss_cnt), 32'h1);
        lock_up();

        // Sticky: clear alone, then clear colliding with a loss
        clr_alone();
        loss(1'b1);
        check("clr_vs_set_sticky", 32'(lock_lost_sticky), 32'h1);
        lock_up();
        clr_alone();
        check("clr_alone_sticky", 32'(lock_lost_sticky), 32'h0);

        // Saturation of the loss counter
        while (n_loss < 260) begin
            loss(1'b0);
            lock_up();
        end
        check("cnt_saturated", 32'(lock_loss_cnt), 32'hff);

        // rst_n mid-release with stage1 out of reset
        loss(1'b0);
        @(negedge clk);
        pll_locked = 1'b1;
        c0 = cyc;
        m_stg = 3'b001; push(c0 + 11);
        m_stg = 3'b011; push(c0 + 15);
        wait_to(c0 + 16);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_stg = '0; m_rdy = 1'b0; m_sticky = 1'b0; m_cnt = '0;
        push(cyc);
        #1;
        check("async_rst_stage", 32'(rst_stage_n), 32'h0);
        check("async_rst_cnt", 32'(lock_loss_cnt), 32'h0);
        check("async_rst_sticky", 32'(lock_lost_sticky), 32'h0);
        wait_to(c0 + 20);
        rst_n = 1'b1;
        c1 = cyc;
        m_stg = 3'b001; push(c1 + 13);
        m_stg = 3'b011; push(c1 + 17);
        m_stg = 3'b111; m_rdy = 1'b1; push(c1 + 21);
        wait_to(c1 + 12);
        check("bridge_delay_stage", 32'(rst_stage_n), 32'h0);
        wait_to(c1 + 21);

        repeat (5) @(negedge clk);
        check("final_stage", 32'(rst_stage_n), 32'h7);
        check("final_ready", 32'(sys_ready), 32'h1);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: cyc %0d, expected finish before timeout", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
